// File: rtl/dcache_sram1.sv
// rtl/dcache_sram1.sv - 512x32 simple dual-port byte-write SRAM bank, read-first, 1-cycle read
// rtl/dcache_sram1.sv - optional macro DCACHE_SRAM1_OUTPUT_REG_EN adds a second read register (2-cycle read)
module dcache_sram1 #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE_WIDTH-1:0]   wr_byte_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // Array has no reset so it maps onto block RAM; writes are only gated by rst.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wr_byte_en[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Non-blocking read of the pre-edge contents gives read-first on collisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

`ifdef DCACHE_SRAM1_OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] rd_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q2 <= '0;
        end else begin
            rd_q2 <= rd_q;
        end
    end

    assign rd_data = rd_q2;
`else
    assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_dcache_sram1.sv
// tb/tb_dcache_sram1.sv - self-checking bench for dcache_sram1 against a byte-level memory model
module tb_dcache_sram1;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int DEPTH = 512;
`ifdef DCACHE_SRAM1_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [BW-1:0] wr_byte_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    always #5 clk = ~clk;

    dcache_sram1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_byte_en (wr_byte_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    typedef struct packed {
        logic          known;
        logic [DW-1:0] val;
    } exp_t;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [BW-1:0] ref_vld [DEPTH];
    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;

    // One clock: drive at negedge, update model at posedge, compare 1 time unit later.
    task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [BW-1:0] be,
                        input logic [AW-1:0] ra, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd; wr_byte_en = be; rd_addr = ra;
        @(posedge clk);
        e.known = r || (ref_vld[ra] == 4'hF);
        e.val   = r ? '0 : ref_mem[ra];
        if (we && !r) begin
            for (int i = 0; i < BW; i++) begin
                if (be[i]) begin
                    ref_mem[wa][8*i +: 8] = wd[8*i +: 8];
                    ref_vld[wa][i] = 1'b1;
                end
            end
        end
        exp_q.push_back(e);
        if (r) begin
            foreach (exp_q[i]) exp_q[i] = '{1'b1, 32'h0};
        end
        while (exp_q.size() > LAT) void'(exp_q.pop_front());
        #1;
        if (exp_q.size() == LAT && exp_q[0].known) begin
            checks++;
            assert (rd_data === exp_q[0].val) else begin
                errors++;
                $error("FAIL %s: rd_data=%h expected=%h", tag, rd_data, exp_q[0].val);
            end
        end
    endtask

    task automatic idle(input int n, input logic [AW-1:0] ra, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, ra, tag);
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            ref_vld[a] = '0;
            ref_mem[a] = '0;
        end
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_byte_en = '0; rd_addr = '0;

        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b1, AW'($urandom), $urandom, 4'hF, AW'($urandom), "reset_hold");

        for (int a = 0; a < DEPTH; a++)
            step(1'b0, 1'b1, AW'(a), 32'hFFFF_FFFF - 32'(a), 4'hF, AW'($urandom), "sweep_write");

        for (int a = 0; a < DEPTH; a++)
            step(a == 200, 1'b0, '0, '0, '0, AW'(a), (a == 200) ? "sweep_mid_reset" : "sweep_read");
        idle(LAT, 9'd201, "sweep_drain");

        step(1'b0, 1'b1, 9'd5, 32'h1122_3344, 4'hF, 9'd0, "be_full");
        step(1'b0, 1'b1, 9'd5, 32'hAABB_CCDD, 4'b0101, 9'd5, "be_partial_before");
        idle(LAT + 1, 9'd5, "be_merge");

        step(1'b0, 1'b1, 9'd7, 32'h0000_0001, 4'hF, 9'd0, "rdw_setup");
        step(1'b0, 1'b1, 9'd7, 32'hDEAD_BEEF, 4'hF, 9'd7, "rdw_read_first");
        idle(LAT + 1, 9'd7, "rdw_new_value");

        step(1'b0, 1'b1, 9'd9, 32'h5A5A_5A5A, 4'hF, 9'd0, "zbe_setup");
        step(1'b0, 1'b1, 9'd9, 32'h0123_4567, 4'h0, 9'd0, "zbe_write");
        idle(LAT + 1, 9'd9, "zbe_read");
        step(1'b1, 1'b1, 9'd9, 32'h0000_0000, 4'hF, 9'd9, "rst_block_write");
        idle(LAT + 1, 9'd9, "rst_block_read");

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)),
                 $urandom, BW'($urandom), AW'($urandom_range(0, 15)), "random");
        idle(LAT + 1, 9'd3, "random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
